// File: rtl/tmr_fault_monitor_pkg.sv
// Shared TMR encodings: voter outcome codes, monitor FSM states and a core-select helper.
package tmr_fault_monitor_pkg;

  typedef enum logic [1:0] {
    VS_AGREE = 2'b00,
    VS_A     = 2'b01,
    VS_B     = 2'b10,
    VS_C     = 2'b11
  } vote_e;

  typedef enum logic [2:0] {
    ST_MONITOR,
    ST_SUSPECT,
    ST_RECOVER,
    ST_HOLD,
    ST_FATAL
  } fsm_e;

  // Voter code to {C,B,A} one-hot; VS_AGREE maps to no core.
  function automatic logic [2:0] core_onehot(input logic [1:0] code);
    logic [2:0] oh;
    oh = '0;
    if (code != VS_AGREE) oh[code - 2'd1] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tmr_fault_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module tmr_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Watches TMR vote outcomes, counts per-core mismatches, pulses a per-core resync on a
// persistently outvoted core and latches Fatal when no majority exists or recoveries run out.
module tmr_fault_monitor
  import tmr_fault_monitor_pkg::*;
#(
  parameter int THRESH     = 4,
  parameter int RST_CYCLES = 8,
  parameter int HOLDOFF    = 16,
  parameter int MAX_RECOV  = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [1:0]       Voter_state,
  input  logic             No_majority,
  input  logic             Clr_cnt,
  output logic [2:0]       Core_rst,
  output logic [CNT_W-1:0] Err_cnt_A,
  output logic [CNT_W-1:0] Err_cnt_B,
  output logic [CNT_W-1:0] Err_cnt_C,
  output logic [1:0]       Faulty_core,
  output logic             Recovering,
  output logic             Fatal
);

  localparam int SW   = $clog2(THRESH + 1);
  localparam int TMAX = (RST_CYCLES > HOLDOFF) ? RST_CYCLES : HOLDOFF;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RECOV < 1) ? 1 : $clog2(MAX_RECOV + 1);

  fsm_e          state, state_n;
  logic [SW-1:0] streak, streak_n, new_streak;
  vote_e         cand, cand_n, vs;
  logic [TW-1:0] timer, timer_n;
  logic [RW-1:0] recov_cnt [3];
  logic [RW-1:0] recov_n   [3];
  logic [1:0]    faulty, faulty_n, idx;
  logic [2:0]    core_rst, core_rst_n;
  logic          sampled;

  assign vs      = vote_e'(Voter_state);
  assign sampled = En && ((state == ST_MONITOR) || (state == ST_SUSPECT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_MONITOR;
      streak    <= '0;
      cand      <= VS_AGREE;
      timer     <= '0;
      recov_cnt <= '{default: '0};
      faulty    <= '0;
      core_rst  <= '0;
    end else begin
      state     <= state_n;
      streak    <= streak_n;
      cand      <= cand_n;
      timer     <= timer_n;
      recov_cnt <= recov_n;
      faulty    <= faulty_n;
      core_rst  <= core_rst_n;
    end
  end

  always_comb begin
    state_n    = state;
    streak_n   = streak;
    cand_n     = cand;
    timer_n    = timer;
    recov_n    = recov_cnt;
    faulty_n   = faulty;
    core_rst_n = core_rst;
    new_streak = '0;
    idx        = Voter_state - 2'd1;
    if (En && No_majority && (state != ST_FATAL)) begin
      state_n    = ST_FATAL;
      core_rst_n = '0;
    end else begin
      unique case (state)
        ST_MONITOR, ST_SUSPECT: begin
          if (En) begin
            if (vs == VS_AGREE) begin
              state_n  = ST_MONITOR;
              streak_n = '0;
            end else begin
              // A different core restarts the streak rather than returning to MONITOR.
              new_streak = ((state == ST_SUSPECT) && (vs == cand)) ? streak + 1'b1 : SW'(1);
              cand_n     = vs;
              if (new_streak >= SW'(THRESH)) begin
                streak_n = '0;
                if (recov_cnt[idx] == RW'(MAX_RECOV)) begin
                  state_n = ST_FATAL;
                end else begin
                  state_n      = ST_RECOVER;
                  core_rst_n   = core_onehot(Voter_state);
                  faulty_n     = Voter_state;
                  recov_n[idx] = recov_cnt[idx] + 1'b1;
                  timer_n      = TW'(RST_CYCLES - 1);
                end
              end else begin
                state_n  = ST_SUSPECT;
                streak_n = new_streak;
              end
            end
          end
        end
        ST_RECOVER: begin
          if (timer == '0) begin
            core_rst_n = '0;
            if (HOLDOFF == 0) begin
              state_n  = ST_MONITOR;
              streak_n = '0;
            end else begin
              state_n = ST_HOLD;
              timer_n = TW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
            end
          end else begin
            timer_n = timer - 1'b1;
          end
        end
        ST_HOLD: begin
          if (timer == '0) begin
            state_n  = ST_MONITOR;
            streak_n = '0;
          end else begin
            timer_n = timer - 1'b1;
          end
        end
        ST_FATAL: state_n = ST_FATAL;
        default:  state_n = ST_MONITOR;
      endcase
    end
  end

  assign Core_rst    = core_rst;
  assign Faulty_core = faulty;
  assign Recovering  = (state == ST_RECOVER) || (state == ST_HOLD);
  assign Fatal       = (state == ST_FATAL);

  tmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk (clk),
    .rst (rst),
    .inc (sampled && !No_majority && (vs == VS_A)),
    .clr (Clr_cnt),
    .cnt (Err_cnt_A)
  );

  tmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk (clk),
    .rst (rst),
    .inc (sampled && !No_majority && (vs == VS_B)),
    .clr (Clr_cnt),
    .cnt (Err_cnt_B)
  );

  tmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_c (
    .clk (clk),
    .rst (rst),
    .inc (sampled && !No_majority && (vs == VS_C)),
    .clr (Clr_cnt),
    .cnt (Err_cnt_C)
  );

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed and randomized checks of tmr_fault_monitor (16-bit and 2-bit counter builds)
// against a countdown-based behavioural model.
module tb_tmr_fault_monitor;

  localparam int THRESH     = 4;
  localparam int RST_CYCLES = 8;
  localparam int HOLDOFF    = 16;
  localparam int MAX_RECOV  = 3;

  logic        clk = 1'b0;
  logic        rst, En, No_majority, Clr_cnt;
  logic [1:0]  Voter_state;
  logic [2:0]  Core_rst, Core_rst2;
  logic [15:0] Err_cnt_A, Err_cnt_B, Err_cnt_C;
  logic [1:0]  Err_cnt_A2, Err_cnt_B2, Err_cnt_C2;
  logic [1:0]  Faulty_core, Faulty_core2;
  logic        Recovering, Recovering2, Fatal, Fatal2;

  always #5 clk = ~clk;

  tmr_fault_monitor #(
    .THRESH(THRESH), .RST_CYCLES(RST_CYCLES), .HOLDOFF(HOLDOFF),
    .MAX_RECOV(MAX_RECOV), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .En(En), .Voter_state(Voter_state),
    .No_majority(No_majority), .Clr_cnt(Clr_cnt), .Core_rst(Core_rst),
    .Err_cnt_A(Err_cnt_A), .Err_cnt_B(Err_cnt_B), .Err_cnt_C(Err_cnt_C),
    .Faulty_core(Faulty_core), .Recovering(Recovering), .Fatal(Fatal)
  );

  tmr_fault_monitor #(
    .THRESH(THRESH), .RST_CYCLES(RST_CYCLES), .HOLDOFF(HOLDOFF),
    .MAX_RECOV(MAX_RECOV), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst), .En(En), .Voter_state(Voter_state),
    .No_majority(No_majority), .Clr_cnt(Clr_cnt), .Core_rst(Core_rst2),
    .Err_cnt_A(Err_cnt_A2), .Err_cnt_B(Err_cnt_B2), .Err_cnt_C(Err_cnt_C2),
    .Faulty_core(Faulty_core2), .Recovering(Recovering2), .Fatal(Fatal2)
  );

  // Model: recovery phase is tracked as remaining pulse/hold cycles, not as FSM states.
  int m_streak, m_cand, m_rst_left, m_hold_left, m_faulty;
  int m_recov [3];
  int m_err   [3];
  int m_err2  [3];
  bit m_fatal;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic void model_reset();
    m_streak = 0; m_cand = 0; m_rst_left = 0; m_hold_left = 0; m_faulty = 0; m_fatal = 0;
    for (int i = 0; i < 3; i++) begin
      m_recov[i] = 0; m_err[i] = 0; m_err2[i] = 0;
    end
  endfunction

  function automatic void model_step(input bit en, input int vs, input bit nm, input bit clr);
    bit busy, sample;
    busy   = (m_rst_left > 0) || (m_hold_left > 0);
    sample = en && !m_fatal && !busy;
    if (sample && !nm && vs != 0) begin
      if (m_err[vs-1]  < 65535) m_err[vs-1]++;
      if (m_err2[vs-1] < 3)     m_err2[vs-1]++;
    end
    if (clr) for (int i = 0; i < 3; i++) begin m_err[i] = 0; m_err2[i] = 0; end
    if (m_fatal) return;
    if (en && nm) begin
      m_fatal = 1; m_rst_left = 0; m_hold_left = 0;
    end else if (m_rst_left > 0) begin
      m_rst_left--;
      if (m_rst_left == 0) m_hold_left = HOLDOFF;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_streak = 0;
    end else if (en) begin
      if (vs == 0) m_streak = 0;
      else begin
        m_streak = (m_streak > 0 && vs == m_cand) ? m_streak + 1 : 1;
        m_cand   = vs;
        if (m_streak >= THRESH) begin
          m_streak = 0;
          if (m_recov[vs-1] == MAX_RECOV) m_fatal = 1;
          else begin
            m_recov[vs-1]++;
            m_faulty   = vs;
            m_rst_left = RST_CYCLES;
          end
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [2:0] exp_rst;
    exp_rst = (m_rst_left > 0) ? (3'b001 << (m_faulty - 1)) : 3'b000;
    chk("core_rst",    32'(Core_rst),    32'(exp_rst));
    chk("faulty_core", 32'(Faulty_core), 32'(m_faulty));
    chk("recovering",  32'(Recovering),  32'((m_rst_left > 0) || (m_hold_left > 0)));
    chk("fatal",       32'(Fatal),       32'(m_fatal));
    chk("err_a",       32'(Err_cnt_A),   32'(m_err[0]));
    chk("err_b",       32'(Err_cnt_B),   32'(m_err[1]));
    chk("err_c",       32'(Err_cnt_C),   32'(m_err[2]));
    chk("core_rst_w2", 32'(Core_rst2),   32'(exp_rst));
    chk("fatal_w2",    32'(Fatal2),      32'(m_fatal));
    chk("err_a_w2",    32'(Err_cnt_A2),  32'(m_err2[0]));
    chk("err_b_w2",    32'(Err_cnt_B2),  32'(m_err2[1]));
    chk("err_c_w2",    32'(Err_cnt_C2),  32'(m_err2[2]));
  endtask

  task automatic step(input bit en, input logic [1:0] vs, input bit nm, input bit clr,
                      input bit r = 1'b0);
    En = en; Voter_state = vs; No_majority = nm; Clr_cnt = clr; rst = r;
    @(posedge clk);
    if (r) model_reset();
    else   model_step(en, int'(vs), nm, clr);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int hi_cnt, hold_cnt, pulses;
    bit saw_rst, prev_c;
    logic [1:0] pat2 [5];
    logic [1:0] pat3 [6];
    logic [1:0] pat6 [8];
    logic [1:0] rv;

    model_reset();
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("reset_core_rst", 32'(Core_rst), 32'd0);
    chk("reset_fatal",    32'(Fatal),    32'd0);

    // 1: four A-outvoted cycles trigger one recovery of A
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 1'b0, 1'b0);
    chk("t1_core_rst", 32'(Core_rst), 32'b001);
    chk("t1_faulty",   32'(Faulty_core), 32'b01);
    hi_cnt = 1; hold_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 2'b00, 1'b0, 1'b0);
      if (Core_rst == 3'b001) hi_cnt++;
      if (Recovering && Core_rst == 3'b000) hold_cnt++;
    end
    chk("t1_pulse_len", 32'(hi_cnt), 32'd8);
    chk("t1_hold_len",  32'(hold_cnt), 32'd16);
    chk("t1_err_a",     32'(Err_cnt_A), 32'd4);
    chk("t1_faulty_kept", 32'(Faulty_core), 32'b01);

    // 2: an agree vote breaks the B streak
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    pat2 = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b10};
    saw_rst = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, pat2[i], 1'b0, 1'b0);
      if (Core_rst != 3'b000) saw_rst = 1;
    end
    chk("t2_err_b", 32'(Err_cnt_B), 32'd4);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 2'b10, 1'b0, 1'b0);
      if (Core_rst != 3'b000) saw_rst = 1;
    end
    chk("t2_no_rst", 32'(saw_rst), 32'd0);
    chk("t2_not_recovering", 32'(Recovering), 32'd0);

    // 3: candidate switch from C to A, then recovery completes with En low
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    pat3 = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 6; i++) step(1'b1, pat3[i], 1'b0, 1'b0);
    chk("t3_core_rst", 32'(Core_rst), 32'b001);
    chk("t3_err_c", 32'(Err_cnt_C), 32'd2);
    chk("t3_err_a", 32'(Err_cnt_A), 32'd4);
    for (int i = 0; i < 25; i++) step(1'b0, 2'b11, 1'b0, 1'b0);
    chk("t3_done", 32'(Recovering), 32'd0);

    // 4: no majority during B recovery is fatal and sticky
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b10, 1'b0, 1'b0);
    chk("t4_core_rst_b", 32'(Core_rst), 32'b010);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b1, 1'b0);
    chk("t4_rst_drop", 32'(Core_rst), 32'b000);
    chk("t4_fatal", 32'(Fatal), 32'd1);
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(1)), 2'($urandom_range(3)), 1'b0, 1'b0);
    chk("t4_fatal_sticky", 32'(Fatal), 32'd1);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("t4_fatal_cleared", 32'(Fatal), 32'd0);

    // 5: the fourth C recovery attempt is fatal
    pulses = 0; prev_c = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        step(1'b1, 2'b11, 1'b0, 1'b0);
        if (Core_rst[2] && !prev_c) pulses++;
        prev_c = Core_rst[2];
      end
      if (k < 3) for (int i = 0; i < 25; i++) begin
        step(1'b1, 2'b00, 1'b0, 1'b0);
        if (Core_rst[2] && !prev_c) pulses++;
        prev_c = Core_rst[2];
      end
    end
    chk("t5_pulses", 32'(pulses), 32'd3);
    chk("t5_fatal", 32'(Fatal), 32'd1);
    chk("t5_no_rst", 32'(Core_rst), 32'd0);

    // 6: 2-bit counter saturation, clear priority, reset mid-hold
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    pat6 = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    for (int i = 0; i < 8; i++) step(1'b1, pat6[i], 1'b0, 1'b0);
    chk("t6_sat", 32'(Err_cnt_A2), 32'd3);
    step(1'b1, 2'b01, 1'b0, 1'b1);
    chk("t6_clr", 32'(Err_cnt_A2), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 2'b00, 1'b0, 1'b0);
    chk("t6_in_hold", 32'(Recovering2 && Core_rst2 == 3'b000), 32'd1);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    chk("t6_rst_recovering", 32'(Recovering2), 32'd0);
    chk("t6_rst_faulty", 32'(Faulty_core2), 32'd0);
    chk("t6_rst_err_a", 32'(Err_cnt_A2), 32'd0);

    // Randomized run: sticky votes build streaks, rare no-majority, clears and resets
    rv = 2'b00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 30) rv = 2'($urandom_range(3));
      if (m_fatal && $urandom_range(7) == 0)
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      else
        step($urandom_range(99) < 90, rv, $urandom_range(299) == 0,
             $urandom_range(99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
